// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: 'W' addr data / 'R' addr become register strobes,
// and each command is answered with one byte ('K', the read data, or '?').
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT = 120000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       wr_en,
  output logic       rd_en,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic [7:0] err_cnt
);

  localparam logic [7:0]  OP_W    = 8'h57;
  localparam logic [7:0]  OP_R    = 8'h52;
  localparam logic [7:0]  RSP_OK  = 8'h4B;
  localparam logic [7:0]  RSP_ERR = 8'h3F;
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, SEND, TX_HOLD, TX_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic        need_sample_q, need_sample_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [23:0] cnt_q, cnt_d;
  logic        err_event;

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    need_sample_d = need_sample_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    tx_data_d     = tx_data_q;
    cnt_d         = '0;
    err_event     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rcv) begin
          if (rx_data == OP_W || rx_data == OP_R) begin
            is_wr_d = (rx_data == OP_W);
            state_d = GET_ADDR;
          end else begin
            tx_data_d = RSP_ERR;
            err_event = 1'b1;
            state_d   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rcv) begin
          addr_d  = rx_data;
          state_d = is_wr_q ? GET_DATA : EXEC;
        end else if (cnt_q == TO_LAST) begin
          err_event = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      GET_DATA: begin
        if (rcv) begin
          wdata_d = rx_data;
          state_d = EXEC;
        end else if (cnt_q == TO_LAST) begin
          err_event = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      EXEC: begin
        err_event = rcv;
        state_d   = SEND;
        if (is_wr_q) tx_data_d = RSP_OK;
        else         need_sample_d = 1'b1;
      end
      SEND: begin
        // Read data is only valid in the first SEND cycle, so capture it here.
        err_event = rcv;
        if (need_sample_q) begin
          tx_data_d     = rdata;
          need_sample_d = 1'b0;
        end
        if (!tx_busy) state_d = TX_HOLD;
      end
      TX_HOLD: begin
        err_event = rcv;
        state_d   = TX_WAIT;
      end
      TX_WAIT: begin
        err_event = rcv;
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = (err_event && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      need_sample_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      tx_data_q     <= '0;
      err_cnt_q     <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      need_sample_q <= need_sample_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      tx_data_q     <= tx_data_d;
      err_cnt_q     <= err_cnt_d;
      cnt_q         <= cnt_d;
    end
  end

  // A read may be sent in the very cycle rdata arrives, so bypass the register then.
  assign tx_data  = need_sample_q ? rdata : tx_data_q;
  assign tx_start = (state_q == SEND) && !tx_busy;
  assign wr_en    = (state_q == EXEC) && is_wr_q;
  assign rd_en    = (state_q == EXEC) && !is_wr_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign err_cnt  = err_cnt_q;

endmodule
